// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command sequencer and its payload buffer.
package spi_pkg;

  localparam int unsigned DefDWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StSend,
    StWaitAck,
    StWaitDone,
    StCsHold
  } seq_state_e;

  // nRF24L01 command opcodes
  localparam logic [7:0] OpRRegister  = 8'h00;
  localparam logic [7:0] OpWRegister  = 8'h20;
  localparam logic [7:0] OpWTxPayload = 8'hA0;
  localparam logic [7:0] OpNop        = 8'hFF;

endpackage

// File: rtl/spi_cmd_buf.sv
// Payload byte buffer: host load/unload pointers with wrap, plus an engine-side port that
// reads the tx byte of a slot and overwrites it with the rx byte.
module spi_cmd_buf #(
  parameter int unsigned D_WIDTH   = spi_pkg::DefDWidth,
  parameter int unsigned BUF_DEPTH = 32,
  parameter int unsigned AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               wr_clr,
  input  logic               rd_en,
  input  logic               rd_clr,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic               eng_we,
  input  logic [AW-1:0]      eng_addr,
  input  logic [D_WIDTH-1:0] eng_wdata,
  output logic [D_WIDTH-1:0] eng_rdata
);

  logic [D_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [D_WIDTH-1:0] rd_data_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_clr) begin
        wr_ptr_q <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rd_clr) begin
        rd_ptr_q <= '0;
      end else if (rd_en) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage is not reset; host and engine writes never overlap since the host is gated to idle.
  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem_q[eng_addr] <= eng_wdata;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign eng_rdata = mem_q[eng_addr];

endmodule

// File: rtl/spi_cmd_seq.sv
// Multi-byte SPI command sequencer: frames one opcode plus N payload bytes under a single
// chip select, drives the byte engine handshake and collects the returned bytes.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int unsigned  D_WIDTH   = DefDWidth,
  parameter int unsigned  BUF_DEPTH = 32,
  parameter int unsigned  CS_SETUP  = 2,
  parameter int unsigned  CS_HOLD   = 2,
  parameter int unsigned  ACK_TMO   = 16,
  localparam int unsigned LW        = $clog2(BUF_DEPTH + 1),
  localparam int unsigned AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic [D_WIDTH-1:0] cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  output logic [D_WIDTH-1:0] status_byte,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               spi_enable,
  output logic [D_WIDTH-1:0] spi_tx_data,
  input  logic [D_WIDTH-1:0] spi_rx_data,
  input  logic               spi_busy,
  output logic               csn
);

  localparam int unsigned CW = 16;

  seq_state_e         state_q;
  logic [D_WIDTH-1:0] op_q, tx_q, status_q;
  logic [LW-1:0]      len_q, idx_q;
  logic [CW-1:0]      cnt_q;
  logic               csn_q, busy_q, done_q, err_q, en_q;

  logic               idle, start_ok, hold_end, capture;
  logic [AW-1:0]      eng_addr;
  logic [D_WIDTH-1:0] buf_rdata;

  assign idle     = (state_q == StIdle);
  assign start_ok = idle && cmd_start && (cmd_len <= LW'(BUF_DEPTH));
  assign hold_end = (state_q == StCsHold) && (cnt_q + CW'(1) >= CW'(CS_HOLD));
  assign capture  = (state_q == StWaitDone) && !spi_busy;
  // Byte idx of a frame is the opcode at idx 0, then buffer slot idx-1.
  assign eng_addr = AW'(idx_q - LW'(1));

  spi_cmd_buf #(
    .D_WIDTH  (D_WIDTH),
    .BUF_DEPTH(BUF_DEPTH),
    .AW       (AW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && idle && !reset),
    .wr_data  (wr_data),
    .wr_clr   (hold_end && !reset),
    .rd_en    (rd_en && idle && !reset),
    .rd_clr   (start_ok && !reset),
    .rd_data  (rd_data),
    .eng_we   (capture && (idx_q != '0) && !reset),
    .eng_addr (eng_addr),
    .eng_wdata(spi_rx_data),
    .eng_rdata(buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      csn_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      tx_q     <= '0;
      status_q <= '0;
      op_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_start) begin
            if (cmd_len > LW'(BUF_DEPTH)) begin
              err_q <= 1'b1;
            end else begin
              op_q    <= cmd_op;
              len_q   <= cmd_len;
              idx_q   <= '0;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              csn_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StCsSetup;
            end
          end
        end
        StCsSetup: begin
          if (cnt_q + CW'(1) >= CW'(CS_SETUP)) begin
            state_q <= StSend;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StSend: begin
          if (!spi_busy) begin
            en_q    <= 1'b1;
            tx_q    <= (idx_q == '0) ? op_q : buf_rdata;
            cnt_q   <= '0;
            state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (spi_busy) begin
            en_q    <= 1'b0;
            state_q <= StWaitDone;
          end else if (cnt_q + CW'(1) >= CW'(ACK_TMO)) begin
            // Engine never acknowledged: abort the frame but still close csn cleanly.
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StCsHold;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StWaitDone: begin
          if (!spi_busy) begin
            if (idx_q == '0) begin
              status_q <= spi_rx_data;
            end
            idx_q   <= idx_q + LW'(1);
            cnt_q   <= '0;
            state_q <= (idx_q == len_q) ? StCsHold : StSend;
          end
        end
        StCsHold: begin
          if (hold_end) begin
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign csn         = csn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign spi_enable  = en_q;
  assign spi_tx_data = tx_q;
  assign status_byte = status_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: randomized byte engine and payloads checked against a slot-array
// model of the buffer and the expected opcode+payload byte stream of each frame.
module tb_spi_cmd_seq;
  import spi_pkg::*;

  localparam int DEPTH = 32;
  localparam int ACK   = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          cmd_start;
  logic [7:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic [7:0]    status_byte;
  logic          busy;
  logic          done;
  logic          err;
  logic          spi_enable;
  logic [7:0]    spi_tx_data;
  logic [7:0]    spi_rx_data;
  logic          spi_busy;
  logic          csn;

  spi_cmd_seq dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_start  (cmd_start),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .status_byte(status_byte),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .spi_enable (spi_enable),
    .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data),
    .spi_busy   (spi_busy),
    .csn        (csn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte engine model: logs each requested byte, acks after a random delay, returns rx bytes.
  logic [7:0] tx_log[$];
  logic [7:0] eng_rx_q[$];
  bit         eng_mute = 1'b0;
  int         eng_st = 0;
  int         eng_cnt = 0;

  initial begin
    spi_busy    = 1'b0;
    spi_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        spi_busy = 1'b0;
        eng_st   = 0;
      end else begin
        case (eng_st)
          0: if (spi_enable && !eng_mute) begin
            tx_log.push_back(spi_tx_data);
            eng_cnt = int'($urandom_range(0, 2));
            eng_st  = 1;
          end
          1: if (eng_cnt == 0) begin
            spi_busy = 1'b1;
            eng_cnt  = int'($urandom_range(1, 3));
            eng_st   = 2;
          end else eng_cnt--;
          2: if (eng_cnt == 0) begin
            if (eng_rx_q.size() > 0) spi_rx_data = eng_rx_q.pop_front();
            else spi_rx_data = 8'h00;
            spi_busy = 1'b0;
            eng_st   = 0;
          end else eng_cnt--;
          default: eng_st = 0;
        endcase
      end
    end
  end

  int done_cnt = 0;
  int en_cycles = 0;
  int csn_low_cycles = 0;
  int csn_gap = 0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (spi_enable) en_cycles <= en_cycles + 1;
    if (!csn) csn_low_cycles <= csn_low_cycles + 1;
    // csn must be low exactly while a frame is in progress
    if (!reset && busy === csn) csn_gap <= csn_gap + 1;
  end

  // Reference buffer model
  logic [7:0] m_mem[DEPTH];
  bit         m_known[DEPTH];
  int         m_wp;
  int         m_rp;
  logic [7:0] rx_plan[$];

  task automatic host_write(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    m_mem[m_wp]   = b;
    m_known[m_wp] = 1'b1;
    m_wp = (m_wp + 1) % DEPTH;
  endtask

  task automatic host_read(input string tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (m_known[m_rp]) check($sformatf("%s slot%0d", tag, m_rp), 32'(rd_data), 32'(m_mem[m_rp]));
    m_rp = (m_rp + 1) % DEPTH;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input int len,
                           input bit tmo, input bit inject);
    logic [7:0] exp_tx[$];
    logic [7:0] rx[$];
    int d0;
    int e0;
    int n;
    bit seen;
    exp_tx = {};
    exp_tx.push_back(op);
    for (int i = 0; i < len; i++) exp_tx.push_back(m_mem[i]);
    rx = rx_plan;
    rx_plan = {};
    while (rx.size() < len + 1) rx.push_back(8'($urandom));
    eng_rx_q = rx;
    tx_log   = {};
    eng_mute = tmo;
    d0 = done_cnt;
    e0 = en_cycles;
    cmd_op    = op;
    cmd_len   = LW'(len);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    m_rp = 0;
    if (inject) begin
      repeat (2) tick();
      cmd_start = 1'b1;
      cmd_op    = ~op;
      cmd_len   = LW'(1);
      wr_en     = 1'b1;
      wr_data   = 8'hC3;
      rd_en     = 1'b1;
      tick();
      cmd_start = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    tick();
    check({tag, " done count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " csn idle"}, 32'(csn), 32'd1);
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    if (tmo) begin
      check({tag, " err"}, 32'(err), 32'd1);
      check({tag, " tx count"}, 32'(tx_log.size()), 32'd0);
      check({tag, " enable cycles"}, 32'(en_cycles - e0), 32'(ACK));
    end else begin
      check({tag, " err"}, 32'(err), 32'd0);
      check({tag, " tx count"}, 32'(tx_log.size()), 32'(len + 1));
      n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
      for (int i = 0; i < n; i++)
        check($sformatf("%s tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
      check({tag, " status"}, 32'(status_byte), 32'(rx[0]));
      for (int i = 0; i < len; i++) begin
        m_mem[i]   = rx[i + 1];
        m_known[i] = 1'b1;
      end
    end
    eng_mute = 1'b0;
    m_wp = 0;
  endtask

  initial begin
    int d0;
    int s0;
    int len;
    bit seen;
    cmd_start = 1'b0;
    cmd_op    = 8'h00;
    cmd_len   = '0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    rd_en     = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_wp = 0;
    m_rp = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst csn", 32'(csn), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst spi_enable", 32'(spi_enable), 32'd0);
    check("rst spi_tx_data", 32'(spi_tx_data), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst status", 32'(status_byte), 32'd0);
    reset = 1'b0;
    tick();

    rx_plan = {8'h0E};
    run_frame("op_only", OpNop, 0, 1'b0, 1'b0);

    host_write(8'hAA);
    host_write(8'h55);
    rx_plan = {8'h0E, 8'h11, 8'h22};
    run_frame("reg_wr", OpWRegister, 2, 1'b0, 1'b0);
    host_read("reg_wr rd");
    host_read("reg_wr rd");

    // 33 loads: the last one wraps onto slot 0
    for (int i = 0; i < DEPTH + 1; i++) host_write(8'($urandom));
    run_frame("full", OpWTxPayload, DEPTH, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) host_read("full rd");

    d0 = done_cnt;
    s0 = csn_low_cycles;
    cmd_op    = OpWRegister;
    cmd_len   = LW'(DEPTH + 1);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (8) tick();
    check("overrun err", 32'(err), 32'd1);
    check("overrun csn", 32'(csn), 32'd1);
    check("overrun busy", 32'(busy), 32'd0);
    check("overrun csn low cycles", 32'(csn_low_cycles - s0), 32'd0);
    check("overrun done", 32'(done_cnt - d0), 32'd0);

    for (int f = 0; f < 5; f++) begin
      len = int'($urandom_range(0, DEPTH));
      for (int i = 0; i < len + int'($urandom_range(0, 2)); i++) host_write(8'($urandom));
      run_frame($sformatf("rand%0d", f), 8'($urandom), len, 1'b0, 1'b0);
      for (int i = 0; i <= len; i++) host_read($sformatf("rand%0d rd", f));
    end

    for (int i = 0; i < 3; i++) host_write(8'($urandom));
    run_frame("ignored", OpWRegister, 2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) host_read("ignored rd");

    run_frame("ack_tmo", OpRRegister, 0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) host_write(8'($urandom));
    tx_log    = {};
    eng_rx_q  = {8'h01, 8'h02, 8'h03, 8'h04};
    cmd_op    = OpWRegister;
    cmd_len   = LW'(3);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (tx_log.size() >= 2) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("midrst reached byte 2", 32'(seen), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    check("midrst csn", 32'(csn), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst spi_enable", 32'(spi_enable), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("midrst no done", 32'(done_cnt - d0), 32'd0);
    m_wp = 0;
    m_rp = 0;
    m_known[0] = 1'b0;

    host_write(8'h3C);
    host_write(8'hC5);
    run_frame("after_rst", OpWRegister, 2, 1'b0, 1'b0);
    host_read("after_rst rd");
    host_read("after_rst rd");

    check("csn tracks busy", 32'(csn_gap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
